r2l_exp: RTL and testbench

R2L_EXP -- requirements
Module: r2l_exp

---
 rtl/r2l_exp_pkg.sv | 16 +
 rtl/mul_lo32.sv | 15 +
 rtl/r2l_exp.sv | 103 ++++++++++
 tb/tb_r2l_exp.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/r2l_exp_pkg.sv
// r2l_exp_pkg: shared widths and FSM state encoding for the r2l_exp block.
//   OPW  - operand width (base A and exponent B)
//   RESW - result / accumulator / squared-base width
//   state_t - IDLE, RUN, DONE; encoding 2'd3 is unused.
package r2l_exp_pkg;

    localparam int unsigned OPW  = 16;
    localparam int unsigned RESW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_lo32.sv
// mul_lo32: combinational 32x32 multiplier keeping only the low 32 bits.
// Ports:
//   a - multiplicand, 32 bits
//   b - multiplier, 32 bits
//   p - low 32 bits of a*b
module mul_lo32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    // Context width is 32 bits, so the high half is dropped (mod 2^32 wrap).
    assign p = a * b;

endmodule

// File: rtl/r2l_exp.sv
// r2l_exp: C = A^B mod 2^32 by right-to-left binary exponentiation, one exponent
// bit per clock.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   start - request, level-sensitive, sampled only in IDLE
//   A     - base, 16-bit unsigned
//   B     - exponent, 16-bit unsigned
//   C     - result, held from DONE entry until the next completed run
//   Done  - high exactly while the FSM is in DONE
module r2l_exp
    import r2l_exp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OPW-1:0]  A,
    input  logic [OPW-1:0]  B,
    output logic [RESW-1:0] C,
    output logic            Done
);

    state_t          state_q, state_d;
    logic [RESW-1:0] r_q, r_d;
    logic [RESW-1:0] base_q, base_d;
    logic [OPW-1:0]  e_q, e_d;
    logic [RESW-1:0] c_q, c_d;

    logic [RESW-1:0] r_mul;
    logic [RESW-1:0] base_sq;

    mul_lo32 u_mul_r (
        .a (r_q),
        .b (base_q),
        .p (r_mul)
    );

    mul_lo32 u_mul_sq (
        .a (base_q),
        .b (base_q),
        .p (base_sq)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        base_d  = base_q;
        e_d     = e_q;
        c_d     = c_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = {{(RESW-OPW){1'b0}}, A};
                    e_d     = B;
                    r_d     = 32'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (e_q != '0) begin
                    if (e_q[0]) begin
                        r_d = r_mul;
                    end
                    base_d = base_sq;
                    e_d    = e_q >> 1;
                end else begin
                    c_d     = r_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Held start keeps us here so a stuck request cannot retrigger.
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            r_q     <= 32'd1;
            base_q  <= '0;
            e_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            base_q  <= base_d;
            e_q     <= e_d;
            c_q     <= c_d;
        end
    end

    assign C    = c_q;
    assign Done = (state_q == DONE);

endmodule

// File: tb/tb_r2l_exp.sv
module tb_r2l_exp;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic [31:0] C;
    logic        Done;

    int nvec;
    int nerr;

    r2l_exp dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .C     (C),
        .Done  (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: plain repeated multiplication, wraps at 32 bits.
    function automatic logic [31:0] ref_pow(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < int'(b); i++) r = r * {16'd0, a};
        return r;
    endfunction

    // Edges from the start edge to the first edge where Done is seen high.
    function automatic int ref_lat(input logic [15:0] b);
        return $clog2(int'(b) + 1) + 1;
    endfunction

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (Done) break;
        end
    endtask

    task automatic finish_op(input string name, input logic [31:0] exp_c);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({name, " done low in idle"}, {31'd0, Done}, 32'd0);
        check({name, " C held in idle"}, C, exp_c);
    endtask

    task automatic run_check(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [31:0] exp_c, input int exp_lat);
        int e;
        launch(a, b);
        wait_done(e);
        check({name, " latency"}, e, exp_lat);
        check({name, " done"}, {31'd0, Done}, 32'd1);
        check({name, " result"}, C, exp_c);
        finish_op(name, exp_c);
    endtask

    vec_t tbl[6];

    initial begin
        int e;
        logic [15:0] ra, rb;
        nvec  = 0;
        nerr  = 0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        rst   = 1'b0;

        tbl[0] = '{a: 16'd7, b: 16'd0,      c: 32'd1,          lat: 1};
        tbl[1] = '{a: 16'd0, b: 16'd0,      c: 32'd1,          lat: 1};
        tbl[2] = '{a: 16'd0, b: 16'd5,      c: 32'd0,          lat: 4};
        tbl[3] = '{a: 16'd3, b: 16'd21,     c: 32'd1870418611, lat: 6};
        tbl[4] = '{a: 16'd1, b: 16'hFFFF,   c: 32'd1,          lat: 17};
        tbl[5] = '{a: 16'd2, b: 16'd3,      c: 32'd8,          lat: 3};

        #12;
        check("reset C", C, 32'd0);
        check("reset done", {31'd0, Done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 2^14 with start held; inputs change mid-run and must be ignored.
        launch(16'd2, 16'd14);
        @(negedge clk);
        A = 16'd5;
        B = 16'd6;
        wait_done(e);
        check("2^14 latency", e, 32'd5);
        check("2^14 result", C, 32'd16384);
        repeat (3) @(posedge clk);
        #1;
        check("2^14 done held", {31'd0, Done}, 32'd1);
        check("2^14 C held", C, 32'd16384);
        finish_op("2^14", 32'd16384);
        run_check("5^6", 16'd5, 16'd6, 32'd15625, 4);

        for (int i = 0; i < 6; i++)
            run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].lat);

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = (i % 4 == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
            run_check($sformatf("rnd%0d %0d^%0d", i, ra, rb), ra, rb, ref_pow(ra, rb),
                      ref_lat(rb));
        end

        // Abort mid-run: C and Done must clear immediately, no partial result.
        launch(16'd3, 16'hFF00);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort C", C, 32'd0);
        check("abort done", {31'd0, Done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_check("post-reset 2^3", 16'd2, 16'd3, 32'd8, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
